hw2_mac_arbiter: RTL and testbench
==================================

HW2_MAC_ARBITER -- requirements
Module: hw2_mac_arbiter

Interface
REQ-001 Parameter LAT, default 2: datapath pipeline latency in cycles, legal range 1..4.
REQ-002 Clock and reset: one clock, `clk`; `reset` is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester grant/accept strobe.
REQ-007 req_a, req_b, req_c  input  16 each  packed operands, {req1[15:8], req0[7:0]}.
REQ-008 req_s  input  2  per-requester op select: 1 = add, 0 = subtract.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  1  index of the requester that owns rsp_d.
REQ-012 rsp_d  output  16  result.
REQ-013 dp_en  output  1  datapath clock enable; also the gating signal for the datapath.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states: IDLE, EXEC, RESP.
REQ-016 IDLE: req_ready is one-hot toward the granted requester when any req_valid is set, and all-zero otherwise.
REQ-017 A request is accepted on req_valid[i] && req_ready[i]; operands are captured at that edge and the FSM moves to EXEC.
REQ-018 Arbitration is round-robin with a last-grant pointer; when both requesters are valid, the non-last-granted one wins.
REQ-019 After reset the pointer favours requester 0, so requester 0 wins the first contention.
REQ-020 EXEC: dp_en = 1 for exactly LAT cycles, then the FSM moves to RESP.
REQ-021 rsp_valid rises LAT+1 cycles after the accept edge.
REQ-022 RESP: rsp_valid = 1, and rsp_d and rsp_id stay stable until rsp_ready is sampled high.
REQ-023 RESP while rsp_ready is low: no grant is issued and req_ready = 0.
REQ-024 rsp_valid && rsp_ready moves the FSM to IDLE; there is no same-cycle re-grant, so the earliest next accept is one cycle later.
REQ-025 Arithmetic: rsp_d = ((a ± b) * c) mod 2^16, with a±b formed as a 16-bit two's-complement value (a,b,c zero-extended).
REQ-026 Subtract underflow wraps; the product is truncated to 16 bits.
REQ-027 dp_en = 0 in IDLE and RESP; datapath registers hold their value when dp_en is low.
REQ-028 A request arriving while busy waits with req_ready = 0; req_valid must stay asserted until accepted.

Reset
REQ-029 Asynchronous reset forces state IDLE, pointer to requester 0, and req_ready = 0.
REQ-030 Reset forces rsp_valid = 0, rsp_id = 0, rsp_d = 0x0000, dp_en = 0, busy = 0.
REQ-031 Reset asserted in EXEC or RESP drops the in-flight operation; no rsp_valid is produced for it after release.

Configuration
REQ-032 Macro HW2_MAC_ZERO_SKIP_EN enables zero skipping.
REQ-033 When defined, an accepted request with c == 0 goes IDLE -> RESP directly with rsp_d = 0x0000, so rsp_valid rises 1 cycle after accept and dp_en never asserts.
REQ-034 When undefined, c == 0 takes the normal EXEC path (LAT cycles with dp_en = 1) and yields 0x0000.

Structure
REQ-035 Package hw2_mac_pkg holds the state encoding, operand width 8, result width 16, and LAT bounds.
REQ-036 Sub-module hw2_mac_dp holds the LAT-stage add/sub-multiply pipeline, enabled by dp_en; the arbiter holds only the FSM, the pointer and the capture registers.

Verification
REQ-037 Requester 0 add: a=0x10, b=0x05, c=0x03, s=1, LAT=2 -> rsp_d=0x003F, rsp_id=0, rsp_valid 3 cycles after accept.
REQ-038 Subtract with underflow: a=0x05, b=0x10, c=0x02, s=0 -> rsp_d=0xFFEA.
REQ-039 Overflow truncation: a=0xFF, b=0xFF, c=0xFF, s=1 -> rsp_d=0xFC02.
REQ-040 Contention: both requesters valid from reset -> grant order req0, req1, req0; rsp_id sequence 0,1,0.
REQ-041 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_d stable, req_ready=0 throughout; release -> IDLE next cycle.
REQ-042 Zero skip and reset mid-op: c=0x00 with HW2_MAC_ZERO_SKIP_EN -> rsp_valid 1 cycle after accept, dp_en never high; reset pulsed in EXEC -> all outputs 0 and no response after release.

Source files
------------

// File: rtl/hw2_mac_pkg.sv
// Shared definitions for the hw2_mac arbiter and its datapath: FSM state
// encoding, operand/result widths and the legal latency range.
package hw2_mac_pkg;

  localparam int OP_W    = 8;
  localparam int RES_W   = 16;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/hw2_mac_dp.sv
// hw2_mac_dp: LAT-stage add/sub-then-multiply pipeline.
// Stage 1 forms the 16-bit two's-complement a+/-b and registers it with c.
// Stage 2 multiplies, truncating to 16 bits. Any further stages only delay.
// With LAT = 1 the whole computation happens in a single stage.
// Every stage advances only while en_i is high and holds otherwise.
module hw2_mac_dp
  import hw2_mac_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  input  logic [OP_W-1:0]  c_i,
  input  logic             add_i,
  output logic [RES_W-1:0] res_o
);

  logic [RES_W-1:0] sum_w;

  // Operands are zero-extended. A subtract underflow wraps in 16 bits.
  assign sum_w = add_i ? (RES_W'(a_i) + RES_W'(b_i))
                       : (RES_W'(a_i) - RES_W'(b_i));

  if (LAT == 1) begin : g_lat1
    logic [RES_W-1:0] res_q;

    // Single stage: the full add/sub and multiply are registered when enabled.
    always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking (<=) so that all registers
      // update together at the edge, whatever order the statements are in.
      if (reset) res_q <= '0;
      else if (en_i) res_q <= sum_w * RES_W'(c_i);
    end

    assign res_o = res_q;
  end else begin : g_latn
    logic [RES_W-1:0] sum_q;
    logic [OP_W-1:0]  c_q;
    logic [RES_W-1:0] prod_q [LAT-1];

    // Stage 1 registers sum and c. Stage 2 multiplies. Later stages delay the product.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        // NOTE: these pipeline registers are reset, not left to power-up
        // values, because the last stage drives rsp_d, which must read 0 after reset.
        sum_q <= '0;
        c_q   <= '0;
        for (int i = 0; i < LAT - 1; i++) prod_q[i] <= '0;
      end else if (en_i) begin
        sum_q     <= sum_w;
        c_q       <= c_i;
        prod_q[0] <= sum_q * RES_W'(c_q);
        for (int i = 1; i < LAT - 1; i++) prod_q[i] <= prod_q[i-1];
      end
    end

    assign res_o = prod_q[LAT-2];
  end

endmodule

// File: rtl/hw2_mac_arbiter.sv
// hw2_mac_arbiter: two-requester round-robin front end for the MAC datapath.
// The FSM runs IDLE -> EXEC (LAT cycles, dp_en high) -> RESP. It holds the
// response until rsp_ready, then returns to IDLE. Operands are captured at accept.
// LAT must lie in 1..4.
// Build option: define HW2_MAC_ZERO_SKIP_EN to send requests with c == 0
// straight from IDLE to RESP with a zero result and no datapath activity.
module hw2_mac_arbiter
  import hw2_mac_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [15:0] req_c,
  input  logic [1:0]  req_s,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_d,
  output logic        dp_en,
  output logic        busy
);

  localparam logic [1:0] CNT_LAST = 2'(LAT - 1);

  state_e          state_q, state_d;
  logic            prio_q, prio_d;     // requester favoured on contention
  logic [1:0]      cnt_q, cnt_d;       // EXEC cycle counter
  logic [OP_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic            s_q, s_d, id_q, id_d;
  logic            gnt_id;
  logic [1:0]      gnt;
  logic [OP_W-1:0] sel_a, sel_b, sel_c;
  logic            sel_s;
  logic [RES_W-1:0] dp_res;
`ifdef HW2_MAC_ZERO_SKIP_EN
  logic            zero_q, zero_d;
`endif

  // Round-robin grant: on contention the favoured requester wins.
  // No grant is issued outside IDLE or while reset is asserted.
  always_comb begin
    gnt_id = (req_valid == 2'b11) ? prio_q : req_valid[1];
    gnt    = 2'b00;
    if (state_q == IDLE && !reset && req_valid != 2'b00) gnt[gnt_id] = 1'b1;
  end

  assign sel_a = gnt_id ? req_a[15:8] : req_a[7:0];
  assign sel_b = gnt_id ? req_b[15:8] : req_b[7:0];
  assign sel_c = gnt_id ? req_c[15:8] : req_c[7:0];
  assign sel_s = req_s[gnt_id];

  // Next-state, capture and output decode for the IDLE/EXEC/RESP FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    s_d       = s_q;
    id_d      = id_q;
`ifdef HW2_MAC_ZERO_SKIP_EN
    zero_d    = zero_q;
`endif
    dp_en     = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          a_d     = sel_a;
          b_d     = sel_b;
          c_d     = sel_c;
          s_d     = sel_s;
          id_d    = gnt_id;
          prio_d  = ~gnt_id;
          cnt_d   = 2'd0;
          state_d = EXEC;
`ifdef HW2_MAC_ZERO_SKIP_EN
          zero_d  = (sel_c == '0);
          if (sel_c == '0) state_d = RESP;
`endif
        end
      end
      EXEC: begin
        dp_en = 1'b1;
        if (cnt_q == CNT_LAST) state_d = RESP;
        else cnt_d = cnt_q + 2'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, pointer and captured operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      s_q     <= 1'b0;
      id_q    <= 1'b0;
`ifdef HW2_MAC_ZERO_SKIP_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s_q     <= s_d;
      id_q    <= id_d;
`ifdef HW2_MAC_ZERO_SKIP_EN
      zero_q  <= zero_d;
`endif
    end
  end

  hw2_mac_dp #(.LAT(LAT)) u_dp (
    .clk   (clk),
    .reset (reset),
    .en_i  (dp_en),
    .a_i   (a_q),
    .b_i   (b_q),
    .c_i   (c_q),
    .add_i (s_q),
    .res_o (dp_res)
  );

  assign req_ready = gnt;
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
`ifdef HW2_MAC_ZERO_SKIP_EN
  assign rsp_d     = zero_q ? '0 : dp_res;
`else
  assign rsp_d     = dp_res;
`endif

endmodule

// File: tb/tb_hw2_mac_arbiter.sv
// Self-checking bench for hw2_mac_arbiter. It uses a table of single requests,
// then contention, backpressure and reset-mid-operation sequences.
// Expected results go into a scoreboard queue at grant and are popped at response.
module tb_hw2_mac_arbiter;

  localparam int LAT = 2;
`ifdef HW2_MAC_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a, req_b, req_c;
  logic [1:0]  req_s;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_d;
  logic        dp_en;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        id;
    logic [15:0] d;
  } exp_t;

  typedef struct {
    logic        id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic        s;
    logic [15:0] exp;
    int          hold;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  hw2_mac_arbiter #(.LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_s     (req_s),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_d     (rsp_d),
    .dp_en     (dp_en),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
  endtask

  task automatic load_lane(input logic id, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic s);
    if (id) begin
      req_a[15:8] = a; req_b[15:8] = b; req_c[15:8] = c; req_s[1] = s;
    end else begin
      req_a[7:0]  = a; req_b[7:0]  = b; req_c[7:0]  = c; req_s[0] = s;
    end
  endtask

  // Waits for a grant, checks its timing, then the response and the return to IDLE.
  task automatic serve_one(input logic exp_id, input logic [7:0] c_lane,
                           input logic [15:0] exp_d, input bit drop,
                           input int hold, input string tag);
    bit          got    = 1'b0;
    bit          seen   = 1'b0;
    bit          quiet  = 1'b1;
    bit          stable = 1'b1;
    int          n      = 0;
    int          lat    = 0;
    int          dp_cnt = 0;
    int          e_lat;
    int          e_dp;
    logic [15:0] d0;
    exp_t        e;

    e_lat = (ZERO_SKIP && c_lane == 8'h00) ? 1 : LAT + 1;
    e_dp  = (ZERO_SKIP && c_lane == 8'h00) ? 0 : LAT;

    while (!got && n < 20) begin
      #1;
      if (req_ready != 2'b00) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_grant_seen"}, 16'(got), 16'd1);
    if (!got) return;
    check({tag, "_grant"}, 16'(req_ready), exp_id ? 16'h0002 : 16'h0001);
    sb_q.push_back('{id: exp_id, d: exp_d});

    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (drop) req_valid[exp_id] = 1'b0;
      #1;
      lat++;
      if (dp_en) dp_cnt++;
      if (req_ready != 2'b00) quiet = 1'b0;
      if (rsp_valid) seen = 1'b1;
    end
    check({tag, "_rsp_seen"}, 16'(seen), 16'd1);
    if (!seen) begin
      void'(sb_q.pop_front());
      return;
    end
    check({tag, "_latency"}, 16'(lat), 16'(e_lat));
    check({tag, "_dp_en_cycles"}, 16'(dp_cnt), 16'(e_dp));
    check({tag, "_ready_low_busy"}, 16'(quiet), 16'd1);

    d0 = rsp_d;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      if (rsp_d !== d0 || !rsp_valid || req_ready != 2'b00 || !busy) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold_stable"}, 16'(stable), 16'd1);

    rsp_ready = 1'b1;
    #1;
    e = sb_q.pop_front();
    check({tag, "_rsp_d"}, rsp_d, e.d);
    check({tag, "_rsp_id"}, 16'(rsp_id), 16'(e.id));
    check({tag, "_no_same_cycle_regrant"}, 16'(req_ready), 16'h0000);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check({tag, "_idle_busy"}, 16'(busy), 16'd0);
    check({tag, "_idle_rsp_valid"}, 16'(rsp_valid), 16'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 16'(req_ready), 16'h0000);
    check({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd0);
    check({tag, "_rsp_id"}, 16'(rsp_id), 16'd0);
    check({tag, "_rsp_d"}, rsp_d, 16'h0000);
    check({tag, "_dp_en"}, 16'(dp_en), 16'd0);
    check({tag, "_busy"}, 16'(busy), 16'd0);
  endtask

  initial begin
    bit got;
    bit spur;

    reset     = 1'b1;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    req_s     = '0;
    rsp_ready = 1'b0;

    //          id    a      b      c      s     expected   hold
    vecs[0] = '{1'b0, 8'h10, 8'h05, 8'h03, 1'b1, 16'h003F, 0};
    vecs[1] = '{1'b0, 8'h05, 8'h10, 8'h02, 1'b0, 16'hFFEA, 0};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 16'hFC02, 0};
    vecs[3] = '{1'b1, 8'h12, 8'h34, 8'h00, 1'b1, 16'h0000, 0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h10, 1'b0, 16'h07F0, 5};
    vecs[5] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 16'h01FF, 0};
    vecs[6] = '{1'b1, 8'h01, 8'h02, 8'h7F, 1'b1, 16'h017D, 0};

    // Both requesters are valid while reset is held, yet no grant may appear.
    #12;
    check_all_zero("reset");
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;

    // Table of isolated requests, each dropped after acceptance.
    for (int i = 0; i < 7; i++) begin
      load_lane(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s);
      req_valid[vecs[i].id] = 1'b1;
      serve_one(vecs[i].id, vecs[i].c, vecs[i].exp, 1'b1, vecs[i].hold,
                $sformatf("vec%0d", i));
    end

    // Contention from a fresh reset: grants must go 0, 1, 0.
    @(negedge clk);
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    load_lane(1'b0, 8'h10, 8'h05, 8'h03, 1'b1);
    load_lane(1'b1, 8'h05, 8'h10, 8'h02, 1'b0);
    req_valid = 2'b11;
    serve_one(1'b0, 8'h03, 16'h003F, 1'b0, 0, "cont0");
    serve_one(1'b1, 8'h02, 16'hFFEA, 1'b0, 0, "cont1");
    serve_one(1'b0, 8'h03, 16'h003F, 1'b0, 0, "cont2");
    req_valid = 2'b00;

    // Reset pulsed mid-EXEC drops the operation.
    @(negedge clk);
    load_lane(1'b1, 8'h33, 8'h11, 8'h05, 1'b1);
    req_valid = 2'b10;
    #1;
    got = (req_ready == 2'b10);
    check("rst_mid_grant", 16'(got), 16'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("rst_mid_busy_before", 16'(busy), 16'd1);
    check("rst_mid_dp_en_before", 16'(dp_en), 16'd1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    spur = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid || busy || dp_en) spur = 1'b1;
    end
    check("rst_mid_no_response", 16'(spur), 16'd0);
    check("rst_mid_sb_empty", 16'(sb_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
